// File: rtl/mem_stage_lsu.sv
// Pipeline MEM stage: writeback and HI/LO pass-through plus a big-endian multi-cycle load/store unit.
// Latency: non-memory ops 0 cycles; memory ops take IDLE + ACCESS (1..TIMEOUT_CYCLES) + DONE.
// Backpressure: stall_request holds upstream stages; bus_request stays high until bus_ack or timeout.
module mem_stage_lsu #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 15,
    parameter int TIMEOUT_WIDTH  = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [3:0]                mem_op_input,
    input  logic [DATA_WIDTH-1:0]     mem_address_input,
    input  logic [DATA_WIDTH-1:0]     mem_store_data_input,
    input  logic [REG_ADDR_WIDTH-1:0] write_reg_address_input,
    input  logic                      write_reg_enable_input,
    input  logic [DATA_WIDTH-1:0]     write_reg_data_input,
    input  logic [DATA_WIDTH-1:0]     hi_input,
    input  logic [DATA_WIDTH-1:0]     lo_input,
    input  logic                      whilo_input,
    input  logic [DATA_WIDTH-1:0]     bus_read_data,
    input  logic                      bus_ack,
    output logic                      bus_request,
    output logic                      bus_write,
    output logic [DATA_WIDTH-1:0]     bus_address,
    output logic [3:0]                bus_byte_select,
    output logic [DATA_WIDTH-1:0]     bus_write_data,
    output logic [REG_ADDR_WIDTH-1:0] write_reg_address_output,
    output logic                      write_reg_enable_output,
    output logic [DATA_WIDTH-1:0]     write_reg_data_output,
    output logic [DATA_WIDTH-1:0]     hi_output,
    output logic [DATA_WIDTH-1:0]     lo_output,
    output logic                      whilo_output,
    output logic                      stall_request,
    output logic                      misaligned_exception,
    output logic                      bus_timeout_error
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;

    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    generate
        if (DATA_WIDTH != 32) begin : g_width_check
            $error("mem_stage_lsu supports DATA_WIDTH == 32 only");
        end
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2 ** TIMEOUT_WIDTH) - 1) begin : g_timeout_check
            $error("mem_stage_lsu TIMEOUT_CYCLES must fit in TIMEOUT_WIDTH bits and be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                   state;
    logic [3:0]               op_q;
    logic [1:0]               lane_q;
    logic                     bus_write_q;
    logic [DATA_WIDTH-1:0]    bus_address_q;
    logic [3:0]               byte_select_q;
    logic [DATA_WIDTH-1:0]    write_data_q;
    logic [TIMEOUT_WIDTH-1:0] counter_q;
    logic [DATA_WIDTH-1:0]    capture_q;
    logic                     timeout_q;

    logic is_load;
    logic is_store;
    logic is_byte;
    logic is_half;
    logic is_word;
    logic is_mem;
    logic misaligned;
    logic start_access;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_byte  = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        case (mem_op_input)
            OP_LB, OP_LBU: begin is_load  = 1'b1; is_byte = 1'b1; end
            OP_LH, OP_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
            OP_LW:         begin is_load  = 1'b1; is_word = 1'b1; end
            OP_SB:         begin is_store = 1'b1; is_byte = 1'b1; end
            OP_SH:         begin is_store = 1'b1; is_half = 1'b1; end
            OP_SW:         begin is_store = 1'b1; is_word = 1'b1; end
            default: ;
        endcase
    end

    assign is_mem       = is_load | is_store;
    assign misaligned   = (is_half & mem_address_input[0]) |
                          (is_word & (mem_address_input[1:0] != 2'b00));
    assign start_access = (state == ST_IDLE) & is_mem & ~misaligned;

    // Lane 0 is the most significant byte; narrow stores are replicated on every lane they could hit.
    logic [3:0]            byte_select_next;
    logic [DATA_WIDTH-1:0] write_data_next;

    always_comb begin
        byte_select_next = 4'b1111;
        write_data_next  = mem_store_data_input;
        if (is_store && is_byte) begin
            byte_select_next = 4'b1000 >> mem_address_input[1:0];
            write_data_next  = {4{mem_store_data_input[7:0]}};
        end else if (is_store && is_half) begin
            byte_select_next = mem_address_input[1] ? 4'b0011 : 4'b1100;
            write_data_next  = {2{mem_store_data_input[15:0]}};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            op_q          <= 4'd0;
            lane_q        <= 2'd0;
            bus_write_q   <= 1'b0;
            bus_address_q <= '0;
            byte_select_q <= 4'd0;
            write_data_q  <= '0;
            counter_q     <= '0;
            capture_q     <= '0;
            timeout_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_access) begin
                        state         <= ST_ACCESS;
                        op_q          <= mem_op_input;
                        lane_q        <= mem_address_input[1:0];
                        bus_write_q   <= is_store;
                        bus_address_q <= {mem_address_input[DATA_WIDTH-1:2], 2'b00};
                        byte_select_q <= byte_select_next;
                        write_data_q  <= write_data_next;
                        counter_q     <= '0;
                        timeout_q     <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (bus_ack) begin
                        capture_q <= bus_read_data;
                        state     <= ST_DONE;
                    end else if (counter_q == TIMEOUT_LAST) begin
                        capture_q <= '0;
                        timeout_q <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        counter_q <= counter_q + TIMEOUT_WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    // The pipeline advances during DONE, so the op is never re-issued.
                    timeout_q <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic [7:0]            load_byte;
    logic [15:0]           load_half;
    logic [DATA_WIDTH-1:0] load_result;

    always_comb begin
        case (lane_q)
            2'd0:    load_byte = capture_q[31:24];
            2'd1:    load_byte = capture_q[23:16];
            2'd2:    load_byte = capture_q[15:8];
            default: load_byte = capture_q[7:0];
        endcase
        load_half = lane_q[1] ? capture_q[15:0] : capture_q[31:16];
        case (op_q)
            OP_LB:   load_result = {{24{load_byte[7]}}, load_byte};
            OP_LBU:  load_result = {24'd0, load_byte};
            OP_LH:   load_result = {{16{load_half[15]}}, load_half};
            OP_LHU:  load_result = {16'd0, load_half};
            default: load_result = capture_q;
        endcase
    end

    always_comb begin
        write_reg_address_output = write_reg_address_input;
        write_reg_enable_output  = write_reg_enable_input;
        write_reg_data_output    = write_reg_data_input;
        hi_output                = hi_input;
        lo_output                = lo_input;
        whilo_output             = whilo_input;
        bus_request              = 1'b0;
        bus_write                = 1'b0;
        bus_address              = '0;
        bus_byte_select          = 4'd0;
        bus_write_data           = '0;
        stall_request            = 1'b0;
        misaligned_exception     = 1'b0;
        bus_timeout_error        = 1'b0;

        case (state)
            ST_IDLE: begin
                if (is_mem) begin
                    write_reg_enable_output = 1'b0;
                    if (misaligned) begin
                        misaligned_exception = 1'b1;
                    end else begin
                        stall_request         = 1'b1;
                        write_reg_data_output = '0;
                    end
                end
            end
            ST_ACCESS: begin
                bus_request             = 1'b1;
                bus_write               = bus_write_q;
                bus_address             = bus_address_q;
                bus_byte_select         = byte_select_q;
                bus_write_data          = write_data_q;
                stall_request           = 1'b1;
                write_reg_enable_output = 1'b0;
                write_reg_data_output   = '0;
            end
            ST_DONE: begin
                if (timeout_q) begin
                    bus_timeout_error       = 1'b1;
                    write_reg_enable_output = 1'b0;
                    write_reg_data_output   = '0;
                end else if (bus_write_q) begin
                    write_reg_enable_output = 1'b0;
                    write_reg_data_output   = '0;
                end else begin
                    write_reg_data_output = load_result;
                end
            end
            default: ;
        endcase

        if (reset) begin
            write_reg_address_output = '0;
            write_reg_enable_output  = 1'b0;
            write_reg_data_output    = '0;
            hi_output                = '0;
            lo_output                = '0;
            whilo_output             = 1'b0;
            bus_request              = 1'b0;
            bus_write                = 1'b0;
            bus_address              = '0;
            bus_byte_select          = 4'd0;
            bus_write_data           = '0;
            stall_request            = 1'b0;
            misaligned_exception     = 1'b0;
            bus_timeout_error        = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomised scoreboard bench for mem_stage_lsu: driver emulates EX/MEM, responder emulates the bus.
module tb_mem_stage_lsu;
    localparam int T = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  mem_op_input = 4'd0;
    logic [31:0] mem_address_input = 32'd0;
    logic [31:0] mem_store_data_input = 32'd0;
    logic [4:0]  write_reg_address_input = 5'd0;
    logic        write_reg_enable_input = 1'b0;
    logic [31:0] write_reg_data_input = 32'd0;
    logic [31:0] hi_input = 32'd0;
    logic [31:0] lo_input = 32'd0;
    logic        whilo_input = 1'b0;
    logic [31:0] bus_read_data = 32'd0;
    logic        bus_ack = 1'b0;
    logic        bus_request, bus_write, write_reg_enable_output, whilo_output;
    logic        stall_request, misaligned_exception, bus_timeout_error;
    logic [31:0] bus_address, bus_write_data, write_reg_data_output, hi_output, lo_output;
    logic [3:0]  bus_byte_select;
    logic [4:0]  write_reg_address_output;

    mem_stage_lsu #(.REG_ADDR_WIDTH(5), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T), .TIMEOUT_WIDTH(4)) dut (
        .clock(clock), .reset(reset),
        .mem_op_input(mem_op_input), .mem_address_input(mem_address_input),
        .mem_store_data_input(mem_store_data_input),
        .write_reg_address_input(write_reg_address_input),
        .write_reg_enable_input(write_reg_enable_input),
        .write_reg_data_input(write_reg_data_input),
        .hi_input(hi_input), .lo_input(lo_input), .whilo_input(whilo_input),
        .bus_read_data(bus_read_data), .bus_ack(bus_ack),
        .bus_request(bus_request), .bus_write(bus_write), .bus_address(bus_address),
        .bus_byte_select(bus_byte_select), .bus_write_data(bus_write_data),
        .write_reg_address_output(write_reg_address_output),
        .write_reg_enable_output(write_reg_enable_output),
        .write_reg_data_output(write_reg_data_output),
        .hi_output(hi_output), .lo_output(lo_output), .whilo_output(whilo_output),
        .stall_request(stall_request), .misaligned_exception(misaligned_exception),
        .bus_timeout_error(bus_timeout_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr, sd, wd, hi, lo, rdata;
        logic [4:0]  wa;
        logic        we, whilo;
        int          delay;
    } op_t;

    typedef struct {
        logic [4:0]  wa;
        logic        we, mis, tmo, whilo, chk_data;
        logic [31:0] wd, hi, lo;
        int          stall;
    } wb_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr, wdata;
        logic [3:0]  bsel;
        int          cycles;
    } bus_t;

    typedef struct {
        int          delay;
        logic [31:0] rdata;
    } plan_t;

    wb_t   wb_q[$];
    bus_t  bus_q[$];
    plan_t plan_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic op_t mk(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                               input logic [4:0] wa, input logic we, input logic [31:0] wd,
                               input int delay, input logic [31:0] rdata);
        op_t o;
        o.op = op; o.addr = addr; o.sd = sd; o.wa = wa; o.we = we; o.wd = wd;
        o.hi = 32'h1111_0000 + addr; o.lo = 32'h2222_0000 + sd; o.whilo = wa[0];
        o.delay = delay; o.rdata = rdata;
        return o;
    endfunction

    // Reference model: derives the whole transaction outcome from the op and the bus plan.
    task automatic expect_and_drive(input op_t o);
        wb_t   w;
        bus_t  b;
        plan_t p;
        int    size, a, acc;
        bit    ld, st;
        logic [31:0] v;
        size = (o.op == 4'd1 || o.op == 4'd2 || o.op == 4'd8) ? 1 :
               (o.op == 4'd3 || o.op == 4'd4 || o.op == 4'd9) ? 2 :
               (o.op == 4'd5 || o.op == 4'd10) ? 4 : 0;
        ld = (size != 0) && (o.op < 4'd8);
        st = (size != 0) && (o.op >= 4'd8);
        a  = int'(o.addr % 32'd4);
        w.wa = o.wa; w.hi = o.hi; w.lo = o.lo; w.whilo = o.whilo;
        w.we = o.we; w.wd = o.wd; w.chk_data = 1'b1; w.mis = 1'b0; w.tmo = 1'b0; w.stall = 0;
        if (ld || st) begin
            if ((size == 2 && a % 2 != 0) || (size == 4 && a != 0)) begin
                w.mis = 1'b1; w.we = 1'b0; w.chk_data = 1'b0;
            end else begin
                acc = (o.delay < T) ? o.delay + 1 : T;
                w.stall = 1 + acc;
                b.wr = st; b.addr = o.addr - 32'(a); b.cycles = acc;
                b.bsel = 4'hF; b.wdata = o.sd;
                if (st && size == 1) begin
                    b.bsel = 4'(1 << (3 - a));
                    b.wdata = (o.sd & 32'hFF) * 32'h0101_0101;
                end else if (st && size == 2) begin
                    b.bsel = (a == 0) ? 4'hC : 4'h3;
                    b.wdata = (o.sd & 32'hFFFF) * 32'h0001_0001;
                end
                bus_q.push_back(b);
                p.delay = o.delay; p.rdata = o.rdata;
                plan_q.push_back(p);
                if (o.delay >= T) begin
                    w.tmo = 1'b1; w.we = 1'b0; w.wd = 32'd0;
                end else if (st) begin
                    w.we = 1'b0; w.chk_data = 1'b0;
                end else begin
                    v = o.rdata;
                    if (size == 1) begin
                        v = (v >> ((3 - a) * 8)) & 32'hFF;
                        if (o.op == 4'd1 && v >= 32'd128) v = v - 32'd256;
                    end else if (size == 2) begin
                        v = (v >> ((2 - a) * 8)) & 32'hFFFF;
                        if (o.op == 4'd3 && v >= 32'd32768) v = v - 32'd65536;
                    end
                    w.wd = v;
                end
            end
        end
        wb_q.push_back(w);
        mem_op_input = o.op; mem_address_input = o.addr; mem_store_data_input = o.sd;
        write_reg_address_input = o.wa; write_reg_enable_input = o.we;
        write_reg_data_input = o.wd; hi_input = o.hi; lo_input = o.lo; whilo_input = o.whilo;
    endtask

    task automatic issue(input op_t o);
        int n;
        expect_and_drive(o);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (stall_request === 1'b1 && n < 40);
        check("issue_not_consumed", {31'd0, stall_request}, 32'd0);
        @(posedge clock);
        #1;
    endtask

    // Bus responder: acks after the planned number of wait cycles, sprinkles stray acks when idle.
    plan_t cur_plan;
    bit    r_act = 1'b0;
    int    r_cnt = 0;
    always @(negedge clock) begin
        if (reset) begin
            bus_ack = 1'b0;
            r_act = 1'b0;
            plan_q.delete();
        end else if (bus_request) begin
            if (!r_act) begin
                r_act = 1'b1;
                r_cnt = 0;
                if (plan_q.size() > 0) cur_plan = plan_q.pop_front();
                else cur_plan = '{delay: 1000, rdata: 32'd0};
            end
            bus_ack = (r_cnt == cur_plan.delay);
            bus_read_data = bus_ack ? cur_plan.rdata : $urandom();
            r_cnt++;
        end else begin
            r_act = 1'b0;
            bus_ack = ($urandom_range(0, 3) == 0);
            bus_read_data = $urandom();
        end
    end

    // Monitor: checks every cycle's outputs against the queued expectations.
    bus_t cur_bus;
    bit   in_bus = 1'b0;
    int   bus_cyc = 0;
    int   stall_cnt = 0;
    always @(negedge clock) begin
        wb_t e;
        if (mon_en) begin
            if (reset) begin
                check("reset_bus_ctl", {27'd0, bus_request, bus_write, stall_request,
                      misaligned_exception, bus_timeout_error}, 32'd0);
                check("reset_bus_address", bus_address, 32'd0);
                check("reset_bus_bsel", {28'd0, bus_byte_select}, 32'd0);
                check("reset_bus_wdata", bus_write_data, 32'd0);
                check("reset_wb_ctl", {25'd0, write_reg_address_output, write_reg_enable_output,
                      whilo_output}, 32'd0);
                check("reset_wb_data", write_reg_data_output, 32'd0);
                check("reset_hi", hi_output, 32'd0);
                check("reset_lo", lo_output, 32'd0);
                wb_q.delete(); bus_q.delete();
                in_bus = 1'b0; bus_cyc = 0; stall_cnt = 0;
            end else begin
                if (bus_request) begin
                    if (!in_bus) begin
                        check("bus_expected", 32'(bus_q.size() != 0), 32'd1);
                        if (bus_q.size() != 0) cur_bus = bus_q.pop_front();
                        in_bus = 1'b1;
                        bus_cyc = 0;
                    end
                    bus_cyc++;
                    check("bus_write", {31'd0, bus_write}, {31'd0, cur_bus.wr});
                    check("bus_address", bus_address, cur_bus.addr);
                    check("bus_byte_select", {28'd0, bus_byte_select}, {28'd0, cur_bus.bsel});
                    check("bus_write_data", bus_write_data, cur_bus.wdata);
                end else if (in_bus) begin
                    in_bus = 1'b0;
                    check("bus_request_cycles", 32'(bus_cyc), 32'(cur_bus.cycles));
                end
                if (stall_request) begin
                    stall_cnt++;
                    check("stall_flags", {30'd0, misaligned_exception, bus_timeout_error}, 32'd0);
                end else begin
                    check("wb_expected", 32'(wb_q.size() != 0), 32'd1);
                    if (wb_q.size() != 0) begin
                        e = wb_q.pop_front();
                        check("stall_cycles", 32'(stall_cnt), 32'(e.stall));
                        check("wb_address", {27'd0, write_reg_address_output}, {27'd0, e.wa});
                        check("wb_enable", {31'd0, write_reg_enable_output}, {31'd0, e.we});
                        if (e.chk_data) check("wb_data", write_reg_data_output, e.wd);
                        check("misaligned", {31'd0, misaligned_exception}, {31'd0, e.mis});
                        check("timeout", {31'd0, bus_timeout_error}, {31'd0, e.tmo});
                        check("wb_bus_idle", {31'd0, bus_request}, 32'd0);
                        check("hi", hi_output, e.hi);
                        check("lo", lo_output, e.lo);
                        check("whilo", {31'd0, whilo_output}, {31'd0, e.whilo});
                    end
                    stall_cnt = 0;
                end
            end
        end
    end

    initial begin
        op_t o;
        mem_op_input = 4'd5; mem_address_input = 32'h4000; write_reg_address_input = 5'd9;
        write_reg_enable_input = 1'b1; write_reg_data_input = 32'hCAFE_F00D;
        hi_input = 32'h5555_AAAA; lo_input = 32'hAAAA_5555; whilo_input = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        o = mk(4'd0, 32'h0, 32'h0, 5'd7, 1'b1, 32'hDEAD_BEEF, 0, 32'h0);
        o.whilo = 1'b1;
        issue(o);
        issue(mk(4'd1, 32'h0000_1001, 32'h0, 5'd3, 1'b1, 32'h0, 0, 32'h12F4_5678));
        issue(mk(4'd9, 32'h0000_2002, 32'h0000_ABCD, 5'd4, 1'b1, 32'h0, 3, 32'h0));
        issue(mk(4'd5, 32'h0000_3002, 32'h0, 5'd5, 1'b1, 32'h77, 0, 32'h0));
        issue(mk(4'd5, 32'h0000_4000, 32'h0, 5'd6, 1'b1, 32'h0, 99, 32'h0));

        // Reset lands in the second ACCESS cycle of a stuck load.
        expect_and_drive(mk(4'd5, 32'h0000_4000, 32'h0, 5'd8, 1'b1, 32'h0, 99, 32'h0));
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b0;
        issue(mk(4'd0, 32'h0, 32'h0, 5'd10, 1'b1, 32'h1234_5678, 0, 32'h0));
        issue(mk(4'd2, 32'h0000_5003, 32'h0, 5'd11, 1'b1, 32'h0, 0, 32'h0000_00FF));

        for (int i = 0; i < 300; i++) begin
            o = mk(4'($urandom_range(0, 15)), $urandom(), $urandom(), 5'($urandom()),
                   1'($urandom()), $urandom(), int'($urandom_range(0, 5)), $urandom());
            o.hi = $urandom(); o.lo = $urandom(); o.whilo = 1'($urandom());
            issue(o);
        end

        mon_en = 1'b0;
        check("wb_queue_drained", 32'(wb_q.size()), 32'd0);
        check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
